adder_4: RTL and testbench
==========================

# adder_4

Registered 4-bit binary adder with carry-in and carry-out. Computes a + b + cin and presents the 5-bit result as {cout, sum} one clock after the operands are qualified by in_valid. It is a small arithmetic leaf used wherever a clocked nibble add with carry chaining is needed, for example when cascading into wider adders.

## Interface
- WIDTH, 4, operand and sum width; fixed at 4 for this block and not to be overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- a  input  4  unsigned operand A.
- b  input  4  unsigned operand B.
- cin  input  1  carry-in.
- in_valid  input  1  qualifies a, b and cin in the current cycle.
- sum  output  4  registered low 4 bits of a + b + cin.
- cout  output  1  registered carry-out, bit 4 of a + b + cin.
- out_valid  output  1  high for one cycle when sum/cout hold a new result.
- ovf  output  1  registered two's-complement overflow flag; present only with ADDER_4_OVF_EN.

## Operation
- The combinational core is a 4-stage ripple-carry chain of full adders.
  - Per bit i: s[i] = a[i] ^ b[i] ^ c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = cin; cout = c[4].
- Full unsigned result range is 0..31, so {cout, sum} = a + b + cin is exact with no truncation.
  - Example: 15 + 15 + 1 gives cout=1, sum=15.
- On a rising clk edge with in_valid=1: sum and cout load the core result, and out_valid is set to 1.
- On a rising clk edge with in_valid=0: sum, cout and ovf hold their previous values, and out_valid is set to 0.
- Signed overflow (with macro only): ovf = c[3] ^ c[4], registered alongside sum.
- There is no backpressure. Every qualified input produces exactly one result, and back-to-back in_valid gives one result per cycle.
- X/Z on operands while in_valid=0 must not propagate into the registers.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on sum/cout/out_valid after edge N.
- Throughput is 1 operation per cycle.
- Reset values: sum=0, cout=0, out_valid=0, ovf=0.
- Reset takes effect immediately on rst rising, with no clock needed, and overrides in_valid.
- An operation in flight when rst asserts is discarded, and no out_valid pulse follows.
- First sampling edge after reset: the first rising clk with rst=0.
- Operands changing every cycle, including cin toggling every half period relative to operands: only values present at the sampling edge matter.

## Configuration
- ADDER_4_OVF_EN:
  - Defined: the ovf port exists and carries the registered signed-overflow flag as specified above.
  - Undefined: the ovf port and its register are removed; sum, cout and out_valid behaviour is unchanged.

## Test plan
- Reset: assert rst mid-cycle with in_valid=1, a=9, b=9 -> sum=0, cout=0, out_valid=0 immediately, without waiting for a clock edge.
- Zero and identity: a=0, b=0, cin=0, then a=0, b=0, cin=1 -> {0,0} then {0,1}, each one cycle after its sampling edge.
- Carry boundary: a=7, b=8, cin=1 -> cout=1, sum=0; a=15, b=15, cin=1 -> cout=1, sum=15.
- Hold: load a=3, b=4, cin=0 (result 7), then in_valid=0 with a=12, b=12 -> sum stays 7, out_valid=0.
- Exhaustive sweep: stream all 512 (a, b, cin) combinations back-to-back -> each result equals a+b+cin one cycle later, with out_valid continuously high.
- With ADDER_4_OVF_EN:
  - a=7, b=1, cin=0 -> ovf=1, sum=8.
  - a=8, b=8, cin=0 -> ovf=1, cout=1, sum=0.
  - a=5, b=2, cin=0 -> ovf=0.

Source files
------------

// File: rtl/adder_4_if.sv
// Operand/result bundle for the registered nibble adder.
// The ovf signal exists only when ADDER_4_OVF_EN is defined.
interface adder_4_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic [3:0] sum;
  logic       cout;
  logic       out_valid;
`ifdef ADDER_4_OVF_EN
  logic       ovf;

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, out_valid, ovf
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, out_valid, ovf
  );
`else
  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, out_valid
  );
`endif
endinterface

// File: rtl/adder_4.sv
// Registered 4-bit ripple-carry adder producing {cout, sum} one cycle after in_valid.
// Optional registered signed-overflow flag enabled by ADDER_4_OVF_EN.
module adder_4 (
  input logic      clk,
  input logic      rst,
  adder_4_if.slave bus
);
  localparam int WIDTH = 4;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
    assign c[i+1] = (bus.a[i] & bus.b[i]) | (c[i] & (bus.a[i] ^ bus.b[i]));
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  // Hold path selects the registers, so operands with in_valid low never reach them.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = s;
      cout_d  = c[WIDTH];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = valid_q;

`ifdef ADDER_4_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid) begin
      ovf_d = c[WIDTH-1] ^ c[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_adder_4.sv
// Self-checking bench for adder_4: arithmetic reference model plus literal pins.
module tb_adder_4;
  logic clk = 1'b0;
  logic rst = 1'b1;

  adder_4_if bus ();

  adder_4 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: plain integer arithmetic on the values present at each edge.
  logic [4:0] m_res   = '0;
  logic       m_valid = 1'b0;
  logic       m_ovf   = 1'b0;
  int         m_u;
  int         m_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else if (bus.in_valid) begin
      m_u     = int'(bus.a) + int'(bus.b) + int'(bus.cin);
      m_s     = int'($signed(bus.a)) + int'($signed(bus.b)) + int'(bus.cin);
      m_res   = m_u[4:0];
      m_valid = 1'b1;
      m_ovf   = (m_s > 7) || (m_s < -8);
    end else begin
      m_valid = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_valid", int'(bus.out_valid), int'(m_valid));
      check("model_result", int'({bus.cout, bus.sum}), int'(m_res));
`ifdef ADDER_4_OVF_EN
      check("model_ovf", int'(bus.ovf), int'(m_ovf));
`endif
    end
  end

  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(posedge clk);
    #1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] v;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", int'(bus.sum), 0);
    check("reset_cout", int'(bus.cout), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
`ifdef ADDER_4_OVF_EN
    check("reset_ovf", int'(bus.ovf), 0);
`endif
    rst    = 1'b0;
    chk_en = 1'b1;

    op(4'd0, 4'd0, 1'b0);
    settle();
    check("zero_result", int'({bus.cout, bus.sum}), 0);
    check("zero_valid", int'(bus.out_valid), 1);
    op(4'd0, 4'd0, 1'b1);
    settle();
    check("cin_only_result", int'({bus.cout, bus.sum}), 1);

    op(4'd7, 4'd8, 1'b1);
    settle();
    check("carry_7_8_1_cout", int'(bus.cout), 1);
    check("carry_7_8_1_sum", int'(bus.sum), 0);
    op(4'd15, 4'd15, 1'b1);
    settle();
    check("carry_max_cout", int'(bus.cout), 1);
    check("carry_max_sum", int'(bus.sum), 15);

    op(4'd3, 4'd4, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 4'd12;
    bus.b        = 4'd12;
    @(negedge clk);
    check("hold_load_sum", int'(bus.sum), 7);
    settle();
    check("hold_sum", int'(bus.sum), 7);
    check("hold_valid", int'(bus.out_valid), 0);

`ifdef ADDER_4_OVF_EN
    op(4'd7, 4'd1, 1'b0);
    settle();
    check("ovf_7_1", int'(bus.ovf), 1);
    check("ovf_7_1_sum", int'(bus.sum), 8);
    op(4'd8, 4'd8, 1'b0);
    settle();
    check("ovf_8_8", int'(bus.ovf), 1);
    check("ovf_8_8_cout", int'(bus.cout), 1);
    check("ovf_8_8_sum", int'(bus.sum), 0);
    op(4'd5, 4'd2, 1'b0);
    settle();
    check("ovf_5_2", int'(bus.ovf), 0);
`endif

    // Asynchronous reset mid-cycle with an operation pending.
    op(4'd9, 4'd9, 1'b0);
    @(posedge clk);
    #3;
    check("pre_reset_result", int'({bus.cout, bus.sum}), 18);
    rst = 1'b1;
    #1;
    check("async_rst_sum", int'(bus.sum), 0);
    check("async_rst_cout", int'(bus.cout), 0);
    check("async_rst_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("rst_overrides_valid", int'(bus.out_valid), 0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("no_pulse_after_rst", int'(bus.out_valid), 0);

    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #1;
      v            = 9'(i);
      bus.a        = v[8:5];
      bus.b        = v[4:1];
      bus.cin      = v[0];
      bus.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.a        = 4'($urandom);
      bus.b        = 4'($urandom);
      bus.cin      = 1'($urandom);
      #5;
      bus.cin = ~bus.cin;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
